// File: rtl/if_prefetch.sv
// Pipelined multi-outstanding instruction fetch stage with a DEPTH-entry return queue.
// Optional macro IF_PREFETCH_BYPASS_EN: forward an accepted response straight to decode when the queue is empty.
module if_prefetch #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter int unsigned          PC_STEP  = 1,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hold,
  input  logic              i_jump_flag,
  input  logic [ADDR_W-1:0] i_branch_pc,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_inst,
  output logic [ADDR_W-1:0] o_out_pc,
  input  logic              i_out_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [CNT_W-1:0]  r_inflight;
  logic [CNT_W-1:0]  r_discard;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_q_inst [DEPTH];
  logic [ADDR_W-1:0] r_q_pc   [DEPTH];

  logic w_credit_ok;
  logic w_grant;
  logic w_drop;
  logic w_accept;
  logic w_q_valid;
  logic w_push;
  logic w_pop;

  // Credit counts both buffered entries and every in-flight request, stale or not.
  always_comb begin
    w_credit_ok = (SUM_W'(r_inflight) + SUM_W'(r_count)) < SUM_W'(DEPTH);
    o_mem_req   = !i_rst && !i_hold && !i_jump_flag && w_credit_ok;
    o_mem_addr  = r_fetch_pc;
    w_grant     = o_mem_req && i_mem_gnt;
    w_drop      = i_mem_rvalid && (r_discard != '0);
    w_accept    = i_mem_rvalid && (r_discard == '0) && !i_jump_flag && !i_rst;
    w_q_valid   = (r_count != '0);
    w_pop       = w_q_valid && i_out_ready;
  end

`ifdef IF_PREFETCH_BYPASS_EN
  logic w_bypass;

  // Empty queue: the arriving response is presented directly; it is only stored if decode stalls.
  always_comb begin
    w_bypass    = !w_q_valid && w_accept;
    o_out_valid = w_q_valid || w_bypass;
    o_out_inst  = '0;
    o_out_pc    = '0;
    if (w_q_valid) begin
      o_out_inst = r_q_inst[r_rd_ptr];
      o_out_pc   = r_q_pc[r_rd_ptr];
    end else if (w_bypass) begin
      o_out_inst = i_mem_rdata;
      o_out_pc   = r_resp_pc;
    end
    w_push = w_accept && !(w_bypass && i_out_ready);
  end
`else
  // Outputs come from queue registers only; zero when empty.
  always_comb begin
    o_out_valid = w_q_valid;
    o_out_inst  = '0;
    o_out_pc    = '0;
    if (w_q_valid) begin
      o_out_inst = r_q_inst[r_rd_ptr];
      o_out_pc   = r_q_pc[r_rd_ptr];
    end
    w_push = w_accept;
  end
`endif

  // Control state: jump wins over everything except reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (i_jump_flag) begin
      r_fetch_pc <= i_branch_pc;
      r_resp_pc  <= i_branch_pc;
      r_inflight <= r_inflight - CNT_W'(i_mem_rvalid);
      r_discard  <= r_inflight - CNT_W'(i_mem_rvalid);
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + PC_INC;
      end
      case ({w_grant, i_mem_rvalid})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_drop) begin
        r_discard <= r_discard - CNT_W'(1);
      end
      if (w_accept) begin
        r_resp_pc <= r_resp_pc + PC_INC;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= i_mem_rdata;
      r_q_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

  // Credit accounting must make an overflowing push impossible.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(w_push && !w_pop && (r_count == DEPTH_C)));
    end
  end

endmodule
